// File: rtl/sdram_slot_arbiter.sv
// sdram_slot_arbiter
//   Shares one sdram controller port among PORTS bus masters using time slots
//   that advance on slot_stb. With RESERVE=1, every other slot belongs to port 0.
//   With DONATE=1, a reserved slot that port 0 leaves unused goes to the
//   round-robin winner. All other slots go round-robin among the eligible ports.
//
// Ports
//   clk, reset         SDRAM clock; synchronous active-high reset
//   slot_stb           one-clk pulse at each slot boundary
//   req/we/addr/ds/wdata  per-port requests, packed (port i at [i*W +: W])
//   ack                one-clk completion pulse to the owner of the retired slot
//   rdata              read data captured from mem_dout when a slot retires
//   mem_*              registered command to the sdram controller, held for a slot
//   mem_dout           sdram read data
//   slot_owner/busy/reserved  status of the slot currently issued

// Per-port eligibility. A port that owns the slot now ending cannot win the
// next slot: its req is still high until it sees ack, so without this rule it
// would be issued twice.
module sdram_slot_arbiter_lane (
  input  logic req,
  input  logic stale,
  input  logic rr_ok,
  output logic elig_any,
  output logic elig_rr
);
  assign elig_any = req & ~stale;
  assign elig_rr  = elig_any & rr_ok;
endmodule

module sdram_slot_arbiter #(
  parameter int PORTS   = 3,
  parameter int AW      = 25,
  parameter int DW      = 16,
  parameter int RESERVE = 1,
  parameter int DONATE  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                slot_stb,
  input  logic [PORTS-1:0]    req,
  input  logic [PORTS-1:0]    we,
  input  logic [PORTS*AW-1:0] addr,
  input  logic [PORTS*2-1:0]  ds,
  input  logic [PORTS*DW-1:0] wdata,
  output logic [PORTS-1:0]    ack,
  output logic [DW-1:0]       rdata,
  output logic [AW-1:0]       mem_addr,
  output logic [1:0]          mem_ds,
  output logic [DW-1:0]       mem_din,
  output logic                mem_we,
  output logic                mem_oe,
  input  logic [DW-1:0]       mem_dout,
  output logic [2:0]          slot_owner,
  output logic                slot_busy,
  output logic                slot_reserved
);

  localparam logic [3:0] PORTS4 = 4'(PORTS);

  typedef struct packed {
    logic          we;
    logic [1:0]    ds;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } port_req_t;

  // State
  logic       phase;     // 0: next slot is reserved (when RESERVE=1)
  logic [2:0] rr_ptr;    // last round-robin winner
  logic [2:0] owner;
  logic       busy;

  port_req_t [PORTS-1:0] preq;
  logic [PORTS-1:0] stale, elig_any, elig_rr;
  logic [15:0]      elig_rr_ext;

  for (genvar i = 0; i < PORTS; i++) begin : g_port
    assign preq[i]  = {we[i], ds[i*2 +: 2], addr[i*AW +: AW], wdata[i*DW +: DW]};
    assign stale[i] = busy && (owner == 3'(i));
    sdram_slot_arbiter_lane u_lane (
      .req      (req[i]),
      .stale    (stale[i]),
      .rr_ok    (1'((i != 0) || (RESERVE == 0))),
      .elig_any (elig_any[i]),
      .elig_rr  (elig_rr[i])
    );
  end

  // Zero-extended so the rotating scan can index with a fixed 4-bit value.
  assign elig_rr_ext = {{(16-PORTS){1'b0}}, elig_rr};

  logic       res_next, rr_hit, win_hit, take_rr, phase_n;
  logic [2:0] rr_win, win;
  logic [3:0] idx;
  port_req_t  sel;
  logic [PORTS-1:0] ack_n;

  always_comb begin
    res_next = (RESERVE != 0) && !phase;
    phase_n  = (RESERVE != 0) ? ~phase : 1'b1;
    rr_hit   = 1'b0;
    rr_win   = '0;
    idx      = '0;
    // Scan rr_ptr+1, rr_ptr+2, ... modulo PORTS; first eligible wins.
    // rr_ptr+k never exceeds 2*PORTS-1, so one subtraction wraps it.
    for (int k = 1; k <= PORTS; k++) begin
      idx = 4'(rr_ptr) + 4'(k);
      if (idx >= PORTS4) idx = idx - PORTS4;
      if (!rr_hit && elig_rr_ext[idx]) begin
        rr_hit = 1'b1;
        rr_win = idx[2:0];
      end
    end

    win_hit = 1'b0;
    win     = '0;
    take_rr = 1'b0;
    if (res_next && elig_any[0]) begin
      win_hit = 1'b1;
    end else if (!res_next || (DONATE != 0)) begin
      // Free slot, or a reserved slot donated to the round-robin pool.
      win_hit = rr_hit;
      win     = rr_win;
      take_rr = rr_hit;
    end

    sel = '0;
    for (int i = 0; i < PORTS; i++)
      if (win == 3'(i)) sel = preq[i];

    ack_n = '0;
    for (int i = 0; i < PORTS; i++)
      ack_n[i] = (owner == 3'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase         <= 1'b0;
      rr_ptr        <= 3'(PORTS-1);
      owner         <= '0;
      busy          <= 1'b0;
      ack           <= '0;
      rdata         <= '0;
      mem_addr      <= '0;
      mem_din       <= '0;
      mem_ds        <= 2'b11;
      mem_we        <= 1'b0;
      mem_oe        <= 1'b0;
      slot_reserved <= 1'b0;
    end else begin
      ack <= '0;
      if (slot_stb) begin
        // Retire the ending slot.
        if (busy) begin
          rdata <= mem_dout;
          ack   <= ack_n;
        end
        // Issue the next slot.
        phase         <= phase_n;
        slot_reserved <= res_next;
        busy          <= win_hit;
        if (take_rr) rr_ptr <= win;
        if (win_hit) begin
          owner    <= win;
          mem_addr <= sel.addr;
          mem_din  <= sel.wdata;
          mem_we   <= sel.we;
          mem_oe   <= ~sel.we;
          mem_ds   <= sel.we ? sel.ds : 2'b11;
        end else begin
          // Idle: address and data hold, no command.
          mem_we <= 1'b0;
          mem_oe <= 1'b0;
          mem_ds <= 2'b11;
        end
      end
    end
  end

  assign slot_owner = owner;
  assign slot_busy  = busy;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
module tb_sdram_slot_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic slot_stb = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 3 ports, reserve + donate. DUT B: 3 ports, reserve, no donate.
  // DUT C: 4 ports, plain round-robin.
  logic [2:0]       req_a = '0, req_b = '0, we_a = '0;
  logic [2:0][24:0] addr_a = '0;
  logic [2:0][1:0]  ds_a = '0;
  logic [2:0][15:0] wdata_a = '0;
  logic [15:0]      dout_a = '0;
  logic [3:0]       req_c = '0;
  logic [3:0][24:0] addr_c = '0;
  logic [3:0][1:0]  ds_c = '0;
  logic [3:0][15:0] wdata_c = '0;
  logic [15:0]      dout_c = '0;

  logic [2:0]  ack_a, ack_b;
  logic [3:0]  ack_c;
  logic [15:0] rdata_a, rdata_b, rdata_c, din_a, din_b, din_c;
  logic [24:0] maddr_a, maddr_b, maddr_c;
  logic [1:0]  mds_a, mds_b, mds_c;
  logic        mwe_a, mwe_b, mwe_c, moe_a, moe_b, moe_c;
  logic [2:0]  own_a, own_b, own_c;
  logic        busy_a, busy_b, busy_c, res_a, res_b, res_c;

  sdram_slot_arbiter #(.PORTS(3), .RESERVE(1), .DONATE(1)) u_a (
    .clk(clk), .reset(reset), .slot_stb(slot_stb), .req(req_a), .we(we_a),
    .addr(addr_a), .ds(ds_a), .wdata(wdata_a), .ack(ack_a), .rdata(rdata_a),
    .mem_addr(maddr_a), .mem_ds(mds_a), .mem_din(din_a), .mem_we(mwe_a),
    .mem_oe(moe_a), .mem_dout(dout_a), .slot_owner(own_a), .slot_busy(busy_a),
    .slot_reserved(res_a));

  sdram_slot_arbiter #(.PORTS(3), .RESERVE(1), .DONATE(0)) u_b (
    .clk(clk), .reset(reset), .slot_stb(slot_stb), .req(req_b), .we(we_a),
    .addr(addr_a), .ds(ds_a), .wdata(wdata_a), .ack(ack_b), .rdata(rdata_b),
    .mem_addr(maddr_b), .mem_ds(mds_b), .mem_din(din_b), .mem_we(mwe_b),
    .mem_oe(moe_b), .mem_dout(dout_a), .slot_owner(own_b), .slot_busy(busy_b),
    .slot_reserved(res_b));

  sdram_slot_arbiter #(.PORTS(4), .RESERVE(0), .DONATE(1)) u_c (
    .clk(clk), .reset(reset), .slot_stb(slot_stb), .req(req_c), .we(4'b0000),
    .addr(addr_c), .ds(ds_c), .wdata(wdata_c), .ack(ack_c), .rdata(rdata_c),
    .mem_addr(maddr_c), .mem_ds(mds_c), .mem_din(din_c), .mem_we(mwe_c),
    .mem_oe(moe_c), .mem_dout(dout_c), .slot_owner(own_c), .slot_busy(busy_c),
    .slot_reserved(res_c));

  typedef struct packed {
    bit        busy;
    bit [2:0]  owner;
    bit        res;
    bit        chk_mem;
    bit        we;
    bit        oe;
    bit [1:0]  ds;
    bit        chk_addr;
    bit [24:0] addr;
    bit        chk_din;
    bit [15:0] din;
  } slot_t;

  typedef struct packed {
    bit [2:0]  ack;
    bit        chk_rd;
    bit [15:0] rd;
  } ack_t;

  slot_t qa[$], qb[$], qc[$];
  ack_t  qk[$];
  int checks = 0, errors = 0;
  bit chk_b = 0, chk_c = 0;
  bit stb_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic cmp_slot(input string tag, input slot_t e, input logic b, input logic [2:0] o,
                          input logic r, input logic w, input logic oe, input logic [1:0] d,
                          input logic [24:0] a, input logic [15:0] dn);
    chk({tag, "_busy"}, 32'(b), 32'(e.busy));
    chk({tag, "_res"}, 32'(r), 32'(e.res));
    if (e.busy) chk({tag, "_owner"}, 32'(o), 32'(e.owner));
    if (e.chk_mem) begin
      chk({tag, "_we"}, 32'(w), 32'(e.we));
      chk({tag, "_oe"}, 32'(oe), 32'(e.oe));
      chk({tag, "_ds"}, 32'(d), 32'(e.ds));
    end
    if (e.chk_addr) chk({tag, "_addr"}, 32'(a), 32'(e.addr));
    if (e.chk_din)  chk({tag, "_din"}, 32'(dn), 32'(e.din));
  endtask

  always @(posedge clk) stb_seen <= slot_stb && !reset;

  // Monitors: compare each newly issued slot, and every ack pulse, against the queues.
  slot_t ea, eb, ec;
  ack_t  ek;
  always @(negedge clk) begin
    if (stb_seen) begin
      if (qa.size() == 0) chk("slot_a_unexpected", 1, 0);
      else begin ea = qa.pop_front(); cmp_slot("A", ea, busy_a, own_a, res_a, mwe_a, moe_a, mds_a, maddr_a, din_a); end
      if (chk_b) begin
        if (qb.size() == 0) chk("slot_b_unexpected", 1, 0);
        else begin eb = qb.pop_front(); cmp_slot("B", eb, busy_b, own_b, res_b, mwe_b, moe_b, mds_b, maddr_b, din_b); end
      end
      if (chk_c) begin
        if (qc.size() == 0) chk("slot_c_unexpected", 1, 0);
        else begin ec = qc.pop_front(); cmp_slot("C", ec, busy_c, own_c, res_c, mwe_c, moe_c, mds_c, maddr_c, din_c); end
      end
    end
    if (ack_a !== 3'b000) begin
      chk("ack_onehot", 32'($countones(ack_a)), 1);
      if (qk.size() == 0) chk("ack_unexpected", 32'(ack_a), 0);
      else begin
        ek = qk.pop_front();
        chk("ack_vec", 32'(ack_a), 32'(ek.ack));
        if (ek.chk_rd) chk("ack_rdata", 32'(rdata_a), 32'(ek.rd));
      end
    end
  end

  function automatic slot_t mk(input bit b, input bit [2:0] o, input bit r);
    slot_t s;
    s = '0; s.busy = b; s.owner = o; s.res = r;
    return s;
  endfunction

  task automatic pa_read(input bit [2:0] o, input bit r, input bit [24:0] a);
    slot_t s;
    s = mk(1, o, r); s.chk_mem = 1; s.oe = 1; s.ds = 2'b11; s.chk_addr = 1; s.addr = a;
    qa.push_back(s);
  endtask

  task automatic pa_idle(input bit r);
    slot_t s;
    s = mk(0, 0, r); s.chk_mem = 1; s.ds = 2'b11;
    qa.push_back(s);
  endtask

  task automatic pk(input bit [2:0] v, input bit c, input bit [15:0] rd);
    ack_t k;
    k.ack = v; k.chk_rd = c; k.rd = rd;
    qk.push_back(k);
  endtask

  task automatic strobe();
    @(posedge clk); #1 slot_stb = 1'b1;
    @(posedge clk); #1 slot_stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Reset with a strobe pulse during reset that must be ignored.
  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1; slot_stb = 1'b1;
    @(posedge clk); #1;
    chk("rst_we", 32'(mwe_a), 0);
    chk("rst_oe", 32'(moe_a), 0);
    chk("rst_ack", 32'(ack_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    @(posedge clk); #1 slot_stb = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_res", 32'(res_a), 0);
    chk("rst_ds", 32'(mds_a), 3);
    chk("rst_addr", 32'(maddr_a), 0);
    chk("rst_din", 32'(din_a), 0);
    chk("rst_rdata", 32'(rdata_a), 0);
    chk("rst_owner", 32'(own_a), 0);
    chk("rst_busy2", 32'(busy_a), 0);
  endtask

  int own1[6] = '{0, 1, 0, 2, 0, 1};
  int own2[4] = '{1, 2, 1, 2};
  int own3[5] = '{0, 1, 2, 3, 0};
  bit bsy2b[4] = '{0, 1, 0, 1};
  int own2b[4] = '{0, 1, 0, 2};
  slot_t s;

  initial begin
    do_reset();

    // Arbitration order, with C (plain round-robin over 4 ports) alongside.
    for (int i = 0; i < 3; i++) begin addr_a[i] = 25'(32'h100 + i); ds_a[i] = 2'b11; end
    req_a = 3'b111; req_c = 4'b1111; chk_c = 1;
    for (int k = 0; k < 6; k++) begin
      pa_read(3'(own1[k]), (k % 2) == 0, 25'(32'h100 + own1[k]));
      if (k > 0) pk(3'(1 << own1[k-1]), 0, 0);
      if (k < 5) qc.push_back(mk(1, 3'(own3[k]), 0));
      if (k == 5) chk_c = 0;
      strobe();
    end
    req_a = 3'b010; req_c = 4'b0000;
    pa_idle(1); pk(3'b010, 0, 0); strobe();
    req_a = 3'b000;
    pa_idle(0); strobe();

    // Donation (A) versus no donation (B).
    do_reset();
    req_a = 3'b110; req_b = 3'b110; chk_b = 1;
    for (int k = 0; k < 4; k++) begin
      pa_read(3'(own2[k]), (k % 2) == 0, 25'(32'h100 + own2[k]));
      if (k > 0) pk(3'(1 << own2[k-1]), 0, 0);
      qb.push_back(mk(bsy2b[k], 3'(own2b[k]), (k % 2) == 0));
      strobe();
    end
    req_a = 3'b100; req_b = 3'b100;
    pa_idle(1); pk(3'b100, 0, 0); qb.push_back(mk(0, 0, 1)); strobe();
    req_a = 3'b000; req_b = 3'b000;
    pa_idle(0); qb.push_back(mk(0, 0, 0)); strobe();
    chk_b = 0;

    // Read data return.
    do_reset();
    addr_a[1] = 25'h0000123; req_a = 3'b010;
    pa_read(1, 1, 25'h0000123); strobe();
    dout_a = 16'hBEEF;
    pk(3'b010, 1, 16'hBEEF); pa_idle(0); strobe();
    dout_a = 16'h0000; req_a = 3'b000;
    pa_idle(1); strobe();

    // Write with byte strobes; idle slots afterwards hold addr/din.
    do_reset();
    addr_a[2] = 25'h1ABCDEF; we_a[2] = 1'b1; ds_a[2] = 2'b01; wdata_a[2] = 16'h55AA;
    req_a = 3'b100;
    s = mk(1, 2, 1); s.chk_mem = 1; s.we = 1; s.oe = 0; s.ds = 2'b01;
    s.chk_addr = 1; s.addr = 25'h1ABCDEF; s.chk_din = 1; s.din = 16'h55AA;
    qa.push_back(s); strobe();
    s = mk(0, 0, 0); s.chk_mem = 1; s.ds = 2'b11;
    s.chk_addr = 1; s.addr = 25'h1ABCDEF; s.chk_din = 1; s.din = 16'h55AA;
    pk(3'b100, 0, 0); qa.push_back(s); strobe();
    req_a = 3'b000;
    s.res = 1; qa.push_back(s); strobe();
    we_a = '0; wdata_a = '0; ds_a[2] = 2'b11;

    // Reset while port 1 owns a slot: abandoned, no ack.
    do_reset();
    addr_a[1] = 25'h101; addr_a[2] = 25'h102;
    req_a = 3'b010;
    pa_read(1, 1, 25'h101); strobe();
    req_a = 3'b011;
    do_reset();
    pa_read(0, 1, 25'h100); strobe();
    pk(3'b001, 0, 0); pa_read(1, 0, 25'h101); strobe();
    req_a = 3'b010;
    pk(3'b010, 0, 0); pa_idle(1); strobe();
    req_a = 3'b000;
    pa_idle(0); strobe();

    repeat (4) @(posedge clk);
    #1;
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    chk("qc_drained", 32'(qc.size()), 0);
    chk("ack_drained", 32'(qk.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
